// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: maps byte-addressed RV32 loads/stores onto a word-wide
// memory without byte enables, using read-modify-write for SB/SH.
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]     mem_writedata,
  output logic                      mem_memwrite,
  output logic                      mem_memread,
  input  logic [DATA_WIDTH-1:0]     mem_readdata
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [MEM_ADDR_WIDTH+1:0] r_addr;
  logic [1:0]                r_size;
  logic                      r_unsigned;
  logic                      r_write;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH-1:0]     r_merged;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_rsp_valid;
  logic                      r_rsp_err;

  logic                      w_accept;
  logic                      w_err;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;
  logic [DATA_WIDTH-1:0]     w_load_ext;
  logic [DATA_WIDTH-1:0]     w_merged;
  logic                      w_unused_addr;

  // Address bits above the memory depth are dropped, so accesses wrap.
  assign w_unused_addr = &{1'b1, req_addr[31:MEM_ADDR_WIDTH+2]};

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_err     = (req_size == SZ_RSVD) ||
                     ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  // Lane select and extension of the word returned during READ.
  always_comb begin
    w_byte     = mem_readdata[{r_addr[1:0], 3'b000} +: 8];
    w_half     = r_addr[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    w_load_ext = mem_readdata;
    case (r_size)
      SZ_BYTE: w_load_ext = {{(DATA_WIDTH-8){w_byte[7] & ~r_unsigned}}, w_byte};
      SZ_HALF: w_load_ext = {{(DATA_WIDTH-16){w_half[15] & ~r_unsigned}}, w_half};
      default: w_load_ext = mem_readdata;
    endcase
  end

  always_comb begin
    w_merged = mem_readdata;
    if (r_size == SZ_BYTE)
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_err) begin
          if (!req_write)               w_state_next = READ;
          else if (req_size == SZ_WORD) w_state_next = WRITE;
          else                          w_state_next = MERGE;
        end
      end
      READ:    w_state_next = IDLE;
      MERGE:   w_state_next = WRITE;
      WRITE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Memory strobes decode from the state register so reset removes them at once.
  always_comb begin
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (r_state)
      READ, MERGE: begin
        mem_memread = 1'b1;
        mem_address = r_addr[MEM_ADDR_WIDTH+1:2];
      end
      WRITE: begin
        mem_memwrite  = r_write;
        mem_address   = r_addr[MEM_ADDR_WIDTH+1:2];
        mem_writedata = (r_size == SZ_WORD) ? r_wdata : r_merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_merged    <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr     <= req_addr[MEM_ADDR_WIDTH+1:0];
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_write    <= req_write;
            r_wdata    <= req_wdata;
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rdata     <= '0;
            end
          end
        end
        READ: begin
          r_rdata     <= w_load_ext;
          r_rsp_valid <= 1'b1;
        end
        MERGE:   r_merged <= w_merged;
        WRITE:   r_rsp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rdata;

endmodule
